// File: rtl/fpu_post_norm.sv
// fpu_post_norm
//   Output stage of the FP add/sub datapath. Takes the raw sign, exponent and
//   extended mantissa from the mantissa adder and normalizes them one bit per
//   cycle. It then rounds to nearest-even and packs an IEEE-754 single-precision
//   word together with the exception flags. Only one operation is in flight.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   valid_i      input operation valid (accepted while ready_o is high)
//   ready_o      high in IDLE only
//   sign_i       result sign from the adder
//   exp_i        biased exponent of the larger operand
//   mant_i       {carry, hidden, frac[22:0], guard, round, sticky}
//   exception_i  0 normal, 1 return A, 2 return B, 3 infinity, 4+ error
//   pre_a_i      operand A {sign, exp[7:0], 1, frac[22:0]}
//   pre_b_i      operand B, same format
//   valid_o      result valid, held until ready_i
//   ready_i      downstream accepts the result
//   result_o     packed single-precision result
//   flags_o      {NV, OF, UF, NX}
//
// States
//   IDLE  | waiting for an operation; results of the last one stay on outputs
//   SHIFT | left-normalizing, one bit per cycle
//   ROUND | round to nearest-even and pack
//   DONE  | result valid, waiting for ready_i

module fpu_post_norm #(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [27:0] mant_i,
  input  logic [2:0]  exception_i,
  input  logic [32:0] pre_a_i,
  input  logic [32:0] pre_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);

  localparam int CW = $clog2(MAX_SHIFT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_SHIFT);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_sign, w_sign_nxt;
  // 10-bit signed so that the +1 of carry/round and the overflow compare never wrap
  logic signed [9:0]  r_exp, w_exp_nxt;
  logic [27:0]        r_mant, w_mant_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [31:0]        r_result, w_result_nxt;
  logic [3:0]         r_flags, w_flags_nxt;

  logic               w_inc;
  logic               w_nx;
  logic [24:0]        w_sig_sum;
  logic signed [9:0]  w_exp_rnd;
  logic [22:0]        w_frac_rnd;
  logic               w_ovf;
  logic [27:0]        w_mant_shl;
  logic               w_unused;

  // Round to nearest-even: increment when guard is set and either a lower
  // bit is set or the result LSB is odd (breaks the tie toward even).
  assign w_inc      = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_nx       = |r_mant[2:0];
  assign w_sig_sum  = {1'b0, r_mant[26:3]} + {24'd0, w_inc};
  assign w_exp_rnd  = w_sig_sum[24] ? (r_exp + 10'sd1) : r_exp;
  // On carry-out the significand is 1.000..0, so the fraction is zero
  assign w_frac_rnd = w_sig_sum[24] ? 23'd0 : w_sig_sum[22:0];
  assign w_ovf      = (w_exp_rnd >= 10'sd255);

  assign w_mant_shl = {r_mant[26:0], 1'b0};

  // The operands' explicit hidden bits, the hidden bit of the rounded
  // significand and the carry slot after normalization are never needed.
  assign w_unused = ^{pre_a_i[23], pre_b_i[23], w_sig_sum[23], r_mant[27]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sign   <= w_sign_nxt;
      r_exp    <= w_exp_nxt;
      r_mant   <= w_mant_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_mant_nxt   = r_mant;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;

    unique case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_sign_nxt  = sign_i;
          w_exp_nxt   = $signed({2'b00, exp_i});
          w_mant_nxt  = mant_i;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
          case (exception_i)
            3'd0: begin
              if (mant_i == 28'd0) begin
                w_result_nxt = 32'h0;
                w_flags_nxt  = 4'b0000;
              end else if (mant_i[27]) begin
                // Carry out of the adder: shift right and fold the
                // dropped round bit into sticky.
                w_mant_nxt  = {1'b0, mant_i[27:2], mant_i[1] | mant_i[0]};
                w_exp_nxt   = $signed({2'b00, exp_i}) + 10'sd1;
                w_state_nxt = S_ROUND;
              end else if (mant_i[26]) begin
                w_state_nxt = S_ROUND;
              end else begin
                w_state_nxt = S_SHIFT;
              end
            end
            3'd1: begin
              w_result_nxt = {pre_a_i[32:24], pre_a_i[22:0]};
              w_flags_nxt  = 4'b0000;
            end
            3'd2: begin
              w_result_nxt = {pre_b_i[32:24], pre_b_i[22:0]};
              w_flags_nxt  = 4'b0000;
            end
            3'd3: begin
              // inf - inf with opposite signs is invalid
              if (pre_a_i[32] == pre_b_i[32]) begin
                w_result_nxt = {sign_i, 8'hFF, 23'h0};
                w_flags_nxt  = 4'b0000;
              end else begin
                w_result_nxt = QNAN;
                w_flags_nxt  = 4'b1000;
              end
            end
            default: begin
              w_result_nxt = QNAN;
              w_flags_nxt  = 4'b1000;
            end
          endcase
        end
      end

      S_SHIFT: begin
        if (r_mant[26]) begin
          w_state_nxt = S_ROUND;
        end else if (r_exp == 10'sd1) begin
          // Denormals are not produced: flush to signed zero
          w_result_nxt = {r_sign, 31'h0};
          w_flags_nxt  = 4'b0011;
          w_state_nxt  = S_DONE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_ROUND;
        end else begin
          w_mant_nxt = w_mant_shl;
          w_exp_nxt  = r_exp - 10'sd1;
          w_cnt_nxt  = r_cnt + CW'(1);
          // Leave as soon as the hidden bit lands so k shifts cost k cycles
          if (w_mant_shl[26]) begin
            w_state_nxt = S_ROUND;
          end
        end
      end

      S_ROUND: begin
        if (w_ovf) begin
          w_result_nxt = {r_sign, 8'hFF, 23'h0};
          w_flags_nxt  = 4'b0101;
        end else begin
          w_result_nxt = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
          w_flags_nxt  = {3'b000, w_nx};
        end
        w_state_nxt = S_DONE;
      end

      S_DONE: begin
        if (ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;
  assign flags_o  = r_flags;

endmodule

// File: tb/tb_fpu_post_norm.sv
module tb_fpu_post_norm;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [27:0] mant_i;
  logic [2:0]  exception_i;
  logic [32:0] pre_a_i;
  logic [32:0] pre_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [3:0]  flags_o;

  int n_vec = 0;
  int n_err = 0;

  fpu_post_norm #(.MAX_SHIFT(26)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .mant_i      (mant_i),
    .exception_i (exception_i),
    .pre_a_i     (pre_a_i),
    .pre_b_i     (pre_b_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .flags_o     (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Present one operation on a falling edge; it is accepted on the next rising edge.
  task automatic start_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input logic [2:0] x,
                          input logic [32:0] pa, input logic [32:0] pb);
    @(negedge clk_i);
    check({tag, " ready_o idle"}, 32'(ready_o), 32'd1);
    sign_i      = s;
    exp_i       = e;
    mant_i      = m;
    exception_i = x;
    pre_a_i     = pa;
    pre_b_i     = pb;
    valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  // Latency counts the accept edge as 1.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 200) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check({tag, " valid_o drop"}, 32'(valid_o), 32'd0);
    check({tag, " ready_o back"}, 32'(ready_o), 32'd1);
    ready_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [2:0] x,
                        input logic [32:0] pa, input logic [32:0] pb,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl,
                        input int exp_lat);
    start_op(tag, s, e, m, x, pa, pb);
    wait_valid(tag, exp_lat);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " flags"}, 32'(flags_o), 32'(exp_fl));
    check({tag, " ready_o busy"}, 32'(ready_o), 32'd0);
    finish_op(tag);
  endtask

  initial begin
    rst_ni      = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    sign_i      = 1'b0;
    exp_i       = 8'd0;
    mant_i      = 28'd0;
    exception_i = 3'd0;
    pre_a_i     = 33'd0;
    pre_b_i     = 33'd0;

    #12;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset result_o", result_o, 32'h0);
    check("reset flags_o", 32'(flags_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post-reset valid_o", 32'(valid_o), 32'd0);

    // Normal-path vectors
    run_op("one_plus_one", 1'b0, 8'd127, 28'h8000000, 3'd0, 33'd0, 33'd0, 32'h40000000, 4'b0000, 2);
    run_op("carry_sticky", 1'b0, 8'd127, 28'h8000002, 3'd0, 33'd0, 33'd0, 32'h40000000, 4'b0001, 2);
    run_op("cancel", 1'b0, 8'd127, 28'h0000008, 3'd0, 33'd0, 33'd0, 32'h34000000, 4'b0000, 25);
    run_op("shift1", 1'b0, 8'd127, 28'h2000000, 3'd0, 33'd0, 33'd0, 32'h3F000000, 4'b0000, 3);
    run_op("neg_one", 1'b1, 8'd127, 28'h4000000, 3'd0, 33'd0, 33'd0, 32'hBF800000, 4'b0000, 2);
    run_op("rne_tie_even", 1'b0, 8'd127, 28'h4000004, 3'd0, 33'd0, 33'd0, 32'h3F800000, 4'b0001, 2);
    run_op("rne_tie_odd", 1'b0, 8'd127, 28'h400000C, 3'd0, 33'd0, 33'd0, 32'h3F800002, 4'b0001, 2);
    run_op("rne_carry", 1'b0, 8'd127, 28'h7FFFFFE, 3'd0, 33'd0, 33'd0, 32'h40000000, 4'b0001, 2);
    run_op("overflow", 1'b0, 8'd254, 28'h8000000, 3'd0, 33'd0, 33'd0, 32'h7F800000, 4'b0101, 2);
    run_op("underflow", 1'b0, 8'd3, 28'h0000004, 3'd0, 33'd0, 33'd0, 32'h00000000, 4'b0011, 4);

    // Exception vectors
    run_op("exc_error", 1'b0, 8'd0, 28'd0, 3'd4, 33'd0, 33'd0, 32'h7FC00000, 4'b1000, 1);
    run_op("exc_inf_opp", 1'b0, 8'd0, 28'd0, 3'd3, {1'b0, 8'hFF, 1'b1, 23'h0},
           {1'b1, 8'hFF, 1'b1, 23'h0}, 32'h7FC00000, 4'b1000, 1);
    run_op("exc_inf_same", 1'b1, 8'd0, 28'd0, 3'd3, {1'b1, 8'hFF, 1'b1, 23'h0},
           {1'b1, 8'hFF, 1'b1, 23'h0}, 32'hFF800000, 4'b0000, 1);
    run_op("exc_ret_a", 1'b0, 8'd0, 28'd0, 3'd1, {1'b0, 8'h80, 1'b1, 23'h400000},
           33'd0, 32'h40400000, 4'b0000, 1);
    run_op("exc_ret_b", 1'b0, 8'd0, 28'd0, 3'd2, 33'd0,
           {1'b1, 8'h81, 1'b1, 23'h000001}, 32'hC0800001, 4'b0000, 1);
    run_op("zero", 1'b1, 8'd127, 28'd0, 3'd0, 33'd0, 33'd0, 32'h00000000, 4'b0000, 1);

    // Backpressure: hold ready_i low and offer a competing input
    start_op("bp", 1'b0, 8'd127, 28'h8000000, 3'd0, 33'd0, 33'd0);
    wait_valid("bp", 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      valid_i     = 1'b1;
      exception_i = 3'd4;
      @(posedge clk_i);
      #1;
      check("bp hold valid_o", 32'(valid_o), 32'd1);
      check("bp hold ready_o", 32'(ready_o), 32'd0);
      check("bp hold result_o", result_o, 32'h40000000);
      check("bp hold flags_o", 32'(flags_o), 32'h0);
    end
    @(negedge clk_i);
    valid_i     = 1'b0;
    exception_i = 3'd0;
    finish_op("bp");
    check("bp idle result kept", result_o, 32'h40000000);
    @(posedge clk_i);
    #1;
    check("bp nothing accepted", 32'(valid_o), 32'd0);

    // Reset in the middle of a long normalization
    start_op("rst_mid", 1'b0, 8'd127, 28'h0000008, 3'd0, 33'd0, 33'd0);
    repeat (5) @(posedge clk_i);
    #2;
    check("rst_mid busy before", 32'(ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    check("rst_mid valid_o", 32'(valid_o), 32'd0);
    check("rst_mid ready_o", 32'(ready_o), 32'd1);
    check("rst_mid result_o", result_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    check("rst_mid no result", 32'(valid_o), 32'd0);
    check("rst_mid idle", 32'(ready_o), 32'd1);
    run_op("after_reset", 1'b0, 8'd127, 28'h4000000, 3'd0, 33'd0, 33'd0, 32'h3F800000, 4'b0000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_post_norm.md
Name: fpu_post_norm

Overview:
- Output stage of the FP add/sub datapath. Takes the raw sign/exponent/extended-mantissa result of the mantissa adder, plus the exception code and operand words from pre-normalization.
- Normalizes iteratively (one shift per cycle), rounds to nearest-even and packs an IEEE-754 single-precision word with exception flags.
- Valid/ready handshakes on input and output; one operation in flight.

Parameters:
- MAX_SHIFT, 26, upper bound on left-normalization cycles; also the width bound of the internal shift counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input operation valid
- ready_o  out  1  block can accept (state IDLE)
- sign_i  in  1  result sign from adder
- exp_i  in  8  biased exponent of larger operand
- mant_i  in  28  {carry[27], hidden[26], frac[25:3], guard[2], round[1], sticky[0]}
- exception_i  in  3  0 normal, 1 return A, 2 return B, 3 infinity, 4 error
- pre_a_i  in  33  operand A, {sign, exp[7:0], 1, frac[22:0]}
- pre_b_i  in  33  operand B, same format
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  32  IEEE-754 single result
- flags_o  out  4  {NV, OF, UF, NX}

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; valid_o = 0; result_o = 0; flags_o = 0; all internal registers cleared.
  - ready_o = (state == IDLE).
  - valid_i is ignored while rst_ni is low.
  - Reset mid-operation aborts it; no result is produced.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE, on valid_i && ready_o, latch inputs. Internal exponent is 10-bit signed (overflow and underflow detection). Then:
  - exception 1: result = {pre_a_i[32:24], pre_a_i[22:0]}, flags 0. Go to DONE.
  - exception 2: same packing from pre_b_i. Go to DONE.
  - exception 3:
    - pre_a_i[32] == pre_b_i[32]: result = {sign, 8'hFF, 23'h0}, flags 0.
    - otherwise: result = 0x7FC00000, NV = 1.
    - Go to DONE.
  - exception 4 or any other nonzero code: result = 0x7FC00000, NV = 1. Go to DONE.
  - exception 0, mant_i[27:0] == 0: result = 0x00000000 (+0), flags 0. Go to DONE.
  - exception 0, carry set: shift mantissa right 1; new sticky = old round | old sticky; exp + 1. Go to ROUND.
  - exception 0, hidden set: go to ROUND.
  - exception 0, otherwise: go to SHIFT.
- SHIFT, once per cycle:
  - If hidden bit set: go to ROUND.
  - Else if exp == 1: flush to signed zero {sign, 31'h0}, UF = 1, NX = 1. Go to DONE.
  - Else: shift mantissa left 1, zero fill into sticky; exp − 1.
  - At most MAX_SHIFT iterations.
- ROUND (single cycle):
  - inc = G && (R || S || frac LSB).
  - NX = G | R | S.
  - If inc carries out of the 24-bit significand: significand = 0x800000, exp + 1.
  - If exp ≥ 255: result = {sign, 8'hFF, 23'h0}, OF = 1, NX = 1.
  - Otherwise: result = {sign, exp[7:0], frac}.
  - Go to DONE.
- DONE:
  - valid_o = 1.
  - result_o and flags_o are held stable until ready_i == 1. Then valid_o = 0 next cycle and state = IDLE.
  - ready_o = 0 until IDLE.
  - No new input is accepted in the cycle the result handshake completes.
- Latency, measured as clock edges from input accept to valid_o high:
  - exception or zero path: 1
  - hidden or carry set: 2
  - k left shifts: 2 + k
- result_o and flags_o are registered. They are updated only on entry to DONE and keep their value in IDLE.

Test Plan:
- 1.0+1.0: exp_i = 127, mant_i carry = 1, rest 0 → result_o = 0x40000000, flags 0, valid_o 2 cycles after accept.
- Cancellation: exp_i = 127, mant_i = 28'h0000008 (frac LSB only) → 23 shifts, result_o = 0x34000000, valid_o 25 cycles after accept.
- Round to nearest-even, exp_i = 127, hidden = 1:
  - frac = 0, G = 1, R = S = 0 → 0x3F800000, NX = 1.
  - frac = 1, G = 1 → 0x3F800002, NX = 1.
  - frac = all ones, G = R = 1 → 0x40000000.
- Overflow: exp_i = 254, carry = 1 → 0x7F800000, flags = 4'b0101.
- Underflow: exp_i = 3, only guard bit set → flush, result_o = 0x00000000 (sign 0), UF = NX = 1.
- Exceptions:
  - code 4 → 0x7FC00000, NV.
  - code 3, pre_a sign 0 / pre_b sign 1 → 0x7FC00000, NV.
  - code 1, pre_a_i = {1'b0, 8'h80, 1'b1, 23'h400000} → 0x40400000.
- Backpressure: ready_i = 0 for 5 cycles in DONE → result_o and valid_o stable, ready_o = 0, new valid_i ignored.
- Reset: assert rst_ni low mid-SHIFT → valid_o = 0 immediately, state IDLE, ready_o = 1 after release.
